// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ----------------
// Decode-to-execute pipeline register for an RV32 core. It forwards register
// operands from the MEM and WB stages, selects the immediate or the register
// for operand B, masks shift amounts, detects load-use hazards and registers
// everything into the EX stage.
//
// Ports
//   clk, clrn                     rising-edge clock, async active-low reset
//   d_valid                       decode slot holds a real instruction
//   d_qa, d_qb                    register-file read data for rs1 / rs2
//   d_imm                         decoded immediate
//   d_rs1, d_rs2, d_rd            source / destination register numbers
//   d_aluc                        ALU op code
//   d_aluimm, d_wreg, d_m2reg     B-from-imm / writes rd / is load
//   m_wreg, m_rd, m_res           MEM-stage forward source
//   w_wreg, w_rd, w_data          WB-stage forward source
//   stall, flush                  downstream hold / kill decode instruction
//   e_valid, e_wreg, e_m2reg      registered EX controls
//   e_a, e_b, e_sd                registered operands and store data
//   e_aluc, e_rd                  registered ALU op and destination
//   lu_stall                      combinational load-use hazard
//
// Flow control: on each rising edge the stage does exactly one of, in
// priority order: flush (load a bubble), stall (hold every register),
// lu_stall (load a bubble while decode holds), or load the decode slot.
// A bubble is all-zero registers, so e_valid = 0 marks it.
module ex_operand_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic        d_valid,
  input  logic [31:0] d_qa,
  input  logic [31:0] d_qb,
  input  logic [31:0] d_imm,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic [4:0]  d_rd,
  input  logic [3:0]  d_aluc,
  input  logic        d_aluimm,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic        m_wreg,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_res,
  input  logic        w_wreg,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_data,
  input  logic        stall,
  input  logic        flush,
  output logic        e_valid,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [3:0]  e_aluc,
  output logic [4:0]  e_rd,
  output logic [31:0] e_sd,
  output logic        lu_stall
);

  logic [31:0] fa;
  logic [31:0] fb;
  logic [31:0] b_sel;
  logic [31:0] b_cap;
  logic        is_shift;
  logic        m_hit_a, m_hit_b, w_hit_a, w_hit_b;

  // x0 is never a forward target, so a producer writing rd=0 is ignored.
  assign m_hit_a = m_wreg && (m_rd != 5'd0) && (m_rd == d_rs1);
  assign m_hit_b = m_wreg && (m_rd != 5'd0) && (m_rd == d_rs2);
  assign w_hit_a = w_wreg && (w_rd != 5'd0) && (w_rd == d_rs1);
  assign w_hit_b = w_wreg && (w_rd != 5'd0) && (w_rd == d_rs2);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fa = d_qa;
    if (m_hit_a)      fa = m_res;
    else if (w_hit_a) fa = w_data;
  end

  always_comb begin
    fb = d_qb;
    if (m_hit_b)      fb = m_res;
    else if (w_hit_b) fb = w_data;
  end

  assign is_shift = (d_aluc == 4'b0001) || (d_aluc == 4'b0101) ||
                    (d_aluc == 4'b1101);
  assign b_sel    = d_aluimm ? d_imm : fb;
  // Shifts only use the low five bits of the amount.
  assign b_cap    = is_shift ? {27'd0, b_sel[4:0]} : b_sel;

  // A load in EX cannot supply its data in time for a dependent instruction.
  assign lu_stall = e_valid && e_m2reg && (e_rd != 5'd0) &&
                    ((e_rd == d_rs1) || (e_rd == d_rs2)) && d_valid;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_valid <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_a     <= 32'd0;
      e_b     <= 32'd0;
      e_aluc  <= 4'd0;
      e_rd    <= 5'd0;
      e_sd    <= 32'd0;
    end else if (flush || (!stall && lu_stall)) begin
      e_valid <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_a     <= 32'd0;
      e_b     <= 32'd0;
      e_aluc  <= 4'd0;
      e_rd    <= 5'd0;
      e_sd    <= 32'd0;
    end else if (!stall) begin
      e_valid <= d_valid;
      e_wreg  <= d_valid && d_wreg;
      e_m2reg <= d_valid && d_m2reg;
      e_a     <= fa;
      e_b     <= b_cap;
      e_aluc  <= d_aluc;
      e_rd    <= d_rd;
      e_sd    <= fb;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vectors with hand-computed expected
// EX-stage register contents, checked by a scoreboard monitor.
module tb_ex_operand_stage;

  localparam int W = 108;  // {valid,wreg,m2reg,aluc,rd,a,b,sd}

  logic        clk = 1'b0;
  logic        clrn;
  logic        d_valid, d_aluimm, d_wreg, d_m2reg;
  logic [31:0] d_qa, d_qb, d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [3:0]  d_aluc;
  logic        m_wreg, w_wreg;
  logic [4:0]  m_rd, w_rd;
  logic [31:0] m_res, w_data;
  logic        stall, flush;
  logic        e_valid, e_wreg, e_m2reg, lu_stall;
  logic [31:0] e_a, e_b, e_sd;
  logic [3:0]  e_aluc;
  logic [4:0]  e_rd;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  ex_operand_stage dut (
    .clk(clk), .clrn(clrn), .d_valid(d_valid), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .m_wreg(m_wreg), .m_rd(m_rd), .m_res(m_res),
    .w_wreg(w_wreg), .w_rd(w_rd), .w_data(w_data), .stall(stall),
    .flush(flush), .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
    .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_rd(e_rd), .e_sd(e_sd),
    .lu_stall(lu_stall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(input logic v, input logic w,
      input logic m, input logic [3:0] c, input logic [4:0] rd,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    return {v, w, m, c, rd, a, b, sd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    d_valid = 0; d_aluimm = 0; d_wreg = 0; d_m2reg = 0;
    d_qa = 0; d_qb = 0; d_imm = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    d_aluc = 0; m_wreg = 0; w_wreg = 0; m_rd = 0; w_rd = 0;
    m_res = 0; w_data = 0; stall = 0; flush = 0;
  endtask

  // Driver: inputs are set at the falling edge; this consumes one rising edge
  // and queues what the EX registers must hold afterwards.
  task automatic cycle(input logic [W-1:0] exp);
    @(posedge clk);
    #1 exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {e_valid, e_wreg, e_m2reg, e_aluc, e_rd, e_a, e_b, e_sd};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL ex_regs: got v%0b w%0b m%0b c%h rd%0d a%h b%h sd%h expected v%0b w%0b m%0b c%h rd%0d a%h b%h sd%h",
          a[107], a[106], a[105], a[104:101], a[100:96], a[95:64], a[63:32], a[31:0],
          e[107], e[106], e[105], e[104:101], e[100:96], e[95:64], e[63:32], e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    clrn = 0;
    #12;
    chk("reset_valid", {31'd0, e_valid}, 32'd0);
    chk("reset_a", e_a, 32'd0);
    chk("reset_lu", {31'd0, lu_stall}, 32'd0);
    @(negedge clk);
    clrn = 1;

    // plain capture, first edge after reset loads
    d_valid = 1; d_qa = 5; d_qb = 7; d_rs1 = 1; d_rs2 = 2; d_rd = 3; d_wreg = 1;
    cycle(pk(1, 1, 0, 4'b0000, 3, 5, 7, 7));

    // both forwards match rs1: MEM wins
    d_rs1 = 4; d_rs2 = 9; d_qa = 32'h11; d_qb = 32'h22; d_aluc = 4'b0111; d_rd = 5;
    m_wreg = 1; m_rd = 4; m_res = 32'hAA; w_wreg = 1; w_rd = 4; w_data = 32'hBB;
    cycle(pk(1, 1, 0, 4'b0111, 5, 32'hAA, 32'h22, 32'h22));
    // MEM targets x0 -> WB forward applies
    m_rd = 0;
    cycle(pk(1, 1, 0, 4'b0111, 5, 32'hBB, 32'h22, 32'h22));
    // neither matches -> register file data
    w_rd = 0;
    cycle(pk(1, 1, 0, 4'b0111, 5, 32'h11, 32'h22, 32'h22));
    // rs1 = x0 is never forwarded even with a producer named x0
    d_rs1 = 0; m_rd = 0; m_wreg = 1;
    cycle(pk(1, 1, 0, 4'b0111, 5, 32'h11, 32'h22, 32'h22));
    // MEM match without wreg is ignored; WB forwards rs2 into sd, imm goes to B
    d_rs1 = 4; m_wreg = 0; m_rd = 4; w_wreg = 1; w_rd = 9; w_data = 32'hCC;
    d_aluimm = 1; d_imm = 32'h100; d_aluc = 4'b0000;
    cycle(pk(1, 1, 0, 4'b0000, 5, 32'h11, 32'h100, 32'hCC));
    clear_inputs();

    // sra with immediate: amount masked to five bits
    d_valid = 1; d_wreg = 1; d_rd = 8; d_rs1 = 1; d_rs2 = 2; d_qa = 32'h80;
    d_qb = 32'h22; d_aluc = 4'b1101; d_aluimm = 1; d_imm = 32'hFFFF_FFE3;
    cycle(pk(1, 1, 0, 4'b1101, 8, 32'h80, 32'h3, 32'h22));
    // sll from register: masked
    d_aluimm = 0; d_aluc = 4'b0001; d_qb = 32'h1234_5687;
    cycle(pk(1, 1, 0, 4'b0001, 8, 32'h80, 32'h7, 32'h1234_5687));
    // srl
    d_aluc = 4'b0101;
    cycle(pk(1, 1, 0, 4'b0101, 8, 32'h80, 32'h7, 32'h1234_5687));
    // pass-b is not a shift: full immediate
    d_aluc = 4'b0010; d_aluimm = 1;
    cycle(pk(1, 1, 0, 4'b0010, 8, 32'h80, 32'hFFFF_FFE3, 32'h1234_5687));
    clear_inputs();

    // invalid slot: operands captured, write/load controls cleared
    d_valid = 0; d_wreg = 1; d_m2reg = 1; d_qa = 3; d_qb = 4; d_aluc = 4'b0100;
    d_rd = 7; d_rs1 = 1; d_rs2 = 2;
    cycle(pk(0, 0, 0, 4'b0100, 7, 3, 4, 4));
    clear_inputs();

    // load-use hazard on rs2
    d_valid = 1; d_m2reg = 1; d_wreg = 1; d_rd = 6; d_rs1 = 1; d_rs2 = 2;
    d_qa = 32'h40; d_qb = 32'h50; d_aluimm = 1; d_imm = 8;
    cycle(pk(1, 1, 1, 4'b0000, 6, 32'h40, 8, 32'h50));
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_rd = 10; d_rs1 = 1; d_rs2 = 6; d_qa = 1; d_qb = 2;
    #1 chk("lu_stall_rs2", {31'd0, lu_stall}, 32'd1);
    cycle(pk(0, 0, 0, 4'b0000, 0, 0, 0, 0));
    #1 chk("lu_after_bubble", {31'd0, lu_stall}, 32'd0);
    // reissue: load data now arrives from MEM
    m_wreg = 1; m_rd = 6; m_res = 32'h77;
    cycle(pk(1, 1, 0, 4'b0000, 10, 1, 32'h77, 32'h77));
    clear_inputs();

    // stall holds, stall beats lu_stall, then lu_stall bubbles
    d_valid = 1; d_m2reg = 1; d_wreg = 1; d_rd = 6; d_rs1 = 1; d_rs2 = 2;
    d_qa = 32'h40; d_qb = 32'h50; d_aluimm = 1; d_imm = 8;
    cycle(pk(1, 1, 1, 4'b0000, 6, 32'h40, 8, 32'h50));
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_rd = 11; d_rs1 = 6; d_qa = 32'h99; stall = 1;
    #1 chk("lu_stall_rs1", {31'd0, lu_stall}, 32'd1);
    cycle(pk(1, 1, 1, 4'b0000, 6, 32'h40, 8, 32'h50));
    cycle(pk(1, 1, 1, 4'b0000, 6, 32'h40, 8, 32'h50));
    stall = 0;
    cycle(pk(0, 0, 0, 4'b0000, 0, 0, 0, 0));
    // stall together with flush: bubble
    d_rs1 = 1; d_aluc = 4'b0110;
    cycle(pk(1, 1, 0, 4'b0110, 11, 32'h99, 0, 0));
    stall = 1; flush = 1;
    cycle(pk(0, 0, 0, 4'b0000, 0, 0, 0, 0));
    stall = 0; flush = 0;
    cycle(pk(1, 1, 0, 4'b0110, 11, 32'h99, 0, 0));
    flush = 1;
    cycle(pk(0, 0, 0, 4'b0000, 0, 0, 0, 0));
    clear_inputs();

    // asynchronous reset between edges
    d_valid = 1; d_wreg = 1; d_m2reg = 1; d_rd = 12; d_qa = 32'h1234;
    d_qb = 32'h55; d_rs1 = 1; d_rs2 = 2; d_aluc = 4'b1000;
    cycle(pk(1, 1, 1, 4'b1000, 12, 32'h1234, 32'h55, 32'h55));
    d_rs1 = 12;  // would be a load-use hazard without reset
    #1 clrn = 0;
    #1;
    chk("arst_valid", {31'd0, e_valid}, 32'd0);
    chk("arst_wreg", {31'd0, e_wreg}, 32'd0);
    chk("arst_m2reg", {31'd0, e_m2reg}, 32'd0);
    chk("arst_a", e_a, 32'd0);
    chk("arst_b", e_b, 32'd0);
    chk("arst_sd", e_sd, 32'd0);
    chk("arst_aluc", {28'd0, e_aluc}, 32'd0);
    chk("arst_rd", {27'd0, e_rd}, 32'd0);
    chk("arst_lu", {31'd0, lu_stall}, 32'd0);
    @(negedge clk);
    clrn = 1;
    cycle(pk(1, 1, 1, 4'b1000, 12, 32'h1234, 32'h55, 32'h55));
    clear_inputs();

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the run stalls somewhere.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
